// File: rtl/hpdcache_sram_req_rsp_ctrl.sv
// Request/response front end for a 1RW byte-enable SRAM, plus the response FIFO it uses.
// Latency: read accepted in cycle N is visible on rsp_* in N+2; writes are issued the same cycle.
// Backpressure: reads are credit-gated on FIFO space plus the in-flight read; writes never stall.

// Generic circular FIFO with storage cleared on reset.
// Latency: 1 cycle push-to-head; backpressure is the caller's job (push must not overflow).
module hpdcache_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [W-1:0]     rd_dat,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop    = rd_vld & rd_rdy;
  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_vld, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Overflow would silently drop read data; the credit scheme upstream must prevent it.
  assert property (@(posedge clk) disable iff (rst)
    !(wr_vld && !pop && (cnt == CNT_W'(DEPTH))));

endmodule

module hpdcache_sram_req_rsp_ctrl #(
  parameter int unsigned ADDR_SIZE      = 6,
  parameter int unsigned DATA_SIZE      = 64,
  parameter int unsigned RSP_FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_SIZE-1:0]   req_addr_i,
  input  logic [DATA_SIZE-1:0]   req_wdata_i,
  input  logic [DATA_SIZE/8-1:0] req_be_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_SIZE-1:0]   rsp_rdata_o,
  output logic                   sram_cs_o,
  output logic                   sram_we_o,
  output logic [ADDR_SIZE-1:0]   sram_addr_o,
  output logic [DATA_SIZE-1:0]   sram_wdata_o,
  output logic [DATA_SIZE/8-1:0] sram_wbyteenable_o,
  input  logic [DATA_SIZE-1:0]   sram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  logic             rd_inflight;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   outstanding;
  logic             rsp_pop;
  logic             credit_ok;

  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  assign outstanding = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_inflight};
  // A pop in the same cycle frees the slot the new read will land in two cycles later.
  assign credit_ok   = (outstanding < (CNT_W+1)'(RSP_FIFO_DEPTH)) |
                       ((outstanding == (CNT_W+1)'(RSP_FIFO_DEPTH)) & rsp_pop);
  assign req_ready_o = req_we_i | credit_ok;

  assign sram_cs_o          = req_valid_i & req_ready_o & ~rst;
  assign sram_we_o          = sram_cs_o & req_we_i;
  assign sram_addr_o        = req_addr_i;
  assign sram_wdata_o       = req_wdata_i;
  assign sram_wbyteenable_o = req_we_i ? req_be_i : '0;

  always_ff @(posedge clk) begin
    if (rst) rd_inflight <= 1'b0;
    else     rd_inflight <= sram_cs_o & ~req_we_i;
  end

  hpdcache_fifo #(
    .W     (DATA_SIZE),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (rd_inflight),
    .wr_dat (sram_rdata_i),
    .rd_rdy (rsp_ready_i),
    .rd_vld (rsp_valid_o),
    .rd_dat (rsp_rdata_o),
    .cnt    (fifo_cnt)
  );

endmodule
